// File: rtl/turbo_lane_dispatcher_pkg.sv
// turbo_pifo_pkg: shared types and default configuration for the lane
// dispatcher in front of the interleaved PIFO pipelines.
//   NLANES_DEF / DEPTH_DEF / DW_DEF : default lane count, lane depth, payload width
//   lane_idx_t                      : lane index (LW_DEF bits)
//   occ_t                           : occupancy counter (CW_DEF bits)
//   disp_mode_e                     : push spreading policy
//   lane_onehot()                   : lane index to one-hot lane mask
package turbo_pifo_pkg;

    localparam int NLANES_DEF = 4;
    localparam int DEPTH_DEF  = 256;
    localparam int DW_DEF     = 48;
    localparam int LW_DEF     = $clog2(NLANES_DEF);
    localparam int CW_DEF     = $clog2(DEPTH_DEF + 1);

    typedef logic [LW_DEF-1:0] lane_idx_t;
    typedef logic [CW_DEF-1:0] occ_t;

    typedef enum logic {
        DISP_RR    = 1'b0,
        DISP_LEAST = 1'b1
    } disp_mode_e;

    function automatic logic [NLANES_DEF-1:0] lane_onehot(input lane_idx_t idx);
        lane_onehot      = '0;
        lane_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/turbo_lane_dispatcher_if.sv
// turbo_lane_dispatcher_if: push/pop request bus and per-lane strobe outputs
// of the lane dispatcher.
//   master : request side (drives i_*, observes o_*)
//   slave  : dispatcher side
//   i_push / i_push_data / o_push_ready : push request, payload, backpressure
//   i_pop / i_pop_lane                  : pop request to the head-compare winner
//   i_mode                              : 0 round-robin, 1 least-occupied
//   o_lane_push / o_lane_data           : per-lane push strobe and payload
//   o_lane_pop / o_pop_err              : per-lane pop strobe, dropped-pop flag
//   o_occ                               : per-lane occupancy, lane k at [k*CW +: CW]
interface turbo_lane_dispatcher_if #(
    parameter int DW     = 48,
    parameter int NLANES = 4,
    parameter int DEPTH  = 256
);
    localparam int LW = $clog2(NLANES);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 i_push;
    logic [DW-1:0]        i_push_data;
    logic                 o_push_ready;
    logic                 i_pop;
    logic [LW-1:0]        i_pop_lane;
    logic                 i_mode;
    logic [NLANES-1:0]    o_lane_push;
    logic [NLANES*DW-1:0] o_lane_data;
    logic [NLANES-1:0]    o_lane_pop;
    logic                 o_pop_err;
    logic [NLANES*CW-1:0] o_occ;

    modport master (
        output i_push, i_push_data, i_pop, i_pop_lane, i_mode,
        input  o_push_ready, o_lane_push, o_lane_data, o_lane_pop, o_pop_err, o_occ
    );

    modport slave (
        input  i_push, i_push_data, i_pop, i_pop_lane, i_mode,
        output o_push_ready, o_lane_push, o_lane_data, o_lane_pop, o_pop_err, o_occ
    );

endinterface

// File: rtl/turbo_lane_dispatcher_picker.sv
// turbo_lane_picker: combinational choice of the lane that receives the next push.
//   occ    : per-lane occupancy, lane k at [k*CW +: CW]
//   rr_ptr : round-robin start lane
//   mode   : DISP_RR or DISP_LEAST (only honoured with TURBO_DISP_LEAST_OCC_EN)
//   valid  : at least one lane has room
//   lane   : chosen lane
// Macro TURBO_DISP_LEAST_OCC_EN builds the least-occupied min search; without it
// the picker is round-robin only and mode is ignored.
module turbo_lane_picker
    import turbo_pifo_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int DEPTH  = 256,
    parameter int LW     = $clog2(NLANES),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic [NLANES*CW-1:0] occ,
    input  logic [LW-1:0]        rr_ptr,
    input  disp_mode_e           mode,
    output logic                 valid,
    output logic [LW-1:0]        lane
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] occ_a [NLANES];
    logic          rr_valid;
    logic [LW-1:0] rr_lane;
    logic [LW-1:0] idx;

    for (genvar k = 0; k < NLANES; k++) begin : g_unpack
        assign occ_a[k] = occ[k*CW +: CW];
    end

    // Scan from the farthest offset back to rr_ptr so the closest non-full
    // lane (in rotating order) is the last one written.
    always_comb begin
        rr_valid = 1'b0;
        rr_lane  = '0;
        idx      = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            idx = rr_ptr + LW'(i);
            if (occ_a[idx] < FULL) begin
                rr_valid = 1'b1;
                rr_lane  = idx;
            end
        end
    end

`ifdef TURBO_DISP_LEAST_OCC_EN
    logic [CW-1:0] min_occ;
    logic [LW-1:0] min_lane;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_occ  = occ_a[0];
        min_lane = '0;
        for (int k = 1; k < NLANES; k++) begin
            if (occ_a[k] < min_occ) begin
                min_occ  = occ_a[k];
                min_lane = LW'(k);
            end
        end
    end

    assign valid = (mode == DISP_LEAST) ? (min_occ < FULL) : rr_valid;
    assign lane  = (mode == DISP_LEAST) ? min_lane : rr_lane;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign valid       = rr_valid;
    assign lane        = rr_lane;
`endif

endmodule

// File: rtl/turbo_lane_dispatcher.sv
// turbo_lane_dispatcher: spreads pushes across NLANES PIFO pipelines, forwards
// pops to the requested lane and tracks per-lane occupancy.
//   i_clk  : clock
//   i_arst : asynchronous active-high reset
//   bus    : turbo_lane_dispatcher_if.slave (push/pop requests, lane strobes, occupancy)
// Macro TURBO_DISP_LEAST_OCC_EN enables the least-occupied policy selected by
// bus.i_mode; without it only round-robin is built.
// Occupancy counts dispatched operations; both the full and the empty test use
// the registered counters, so a same-cycle pop never makes room for a push and
// a same-cycle push never rescues a pop.
module turbo_lane_dispatcher
    import turbo_pifo_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NLANES = NLANES_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    turbo_lane_dispatcher_if.slave    bus
);

    localparam int LW = $clog2(NLANES);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]             occ [NLANES];
    logic [NLANES*CW-1:0]      occ_flat;
    logic [LW-1:0]             rr_ptr;
    logic [NLANES-1:0]         lane_push;
    logic [NLANES-1:0]         lane_pop;
    logic [NLANES-1:0][DW-1:0] lane_data;
    logic                      pop_err;

    disp_mode_e                mode;
    logic                      pick_valid;
    logic [LW-1:0]             pick_lane;
    logic                      push_acc;
    logic                      pop_ok;
    logic [NLANES-1:0]         push_oh;
    logic [NLANES-1:0]         pop_oh;

    for (genvar k = 0; k < NLANES; k++) begin : g_flat
        assign occ_flat[k*CW +: CW] = occ[k];
    end

    assign mode = disp_mode_e'(bus.i_mode);

    turbo_lane_picker #(
        .NLANES (NLANES),
        .DEPTH  (DEPTH),
        .LW     (LW),
        .CW     (CW)
    ) u_picker (
        .occ    (occ_flat),
        .rr_ptr (rr_ptr),
        .mode   (mode),
        .valid  (pick_valid),
        .lane   (pick_lane)
    );

    // Some lane has room exactly when the picker finds one.
    assign push_acc = bus.i_push && pick_valid;
    assign pop_ok   = bus.i_pop && (occ[bus.i_pop_lane] != '0);
    assign push_oh  = push_acc ? (NLANES'(1) << pick_lane) : '0;
    assign pop_oh   = pop_ok ? (NLANES'(1) << bus.i_pop_lane) : '0;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            lane_push <= '0;
            lane_pop  <= '0;
            pop_err   <= 1'b0;
            lane_data <= '0;
            rr_ptr    <= '0;
            for (int k = 0; k < NLANES; k++) begin
                occ[k] <= '0;
            end
        end else begin
            lane_push <= push_oh;
            lane_pop  <= pop_oh;
            pop_err   <= bus.i_pop && !pop_ok;
            if (push_acc) begin
                lane_data[pick_lane] <= bus.i_push_data;
            end
            // Push and pop to the same lane cancel out.
            for (int k = 0; k < NLANES; k++) begin
                occ[k] <= occ[k] + CW'(push_oh[k]) - CW'(pop_oh[k]);
            end
`ifdef TURBO_DISP_LEAST_OCC_EN
            if (push_acc && mode == DISP_RR) begin
                rr_ptr <= pick_lane + LW'(1);
            end
`else
            if (push_acc) begin
                rr_ptr <= pick_lane + LW'(1);
            end
`endif
        end
    end

    assign bus.o_push_ready = pick_valid;
    assign bus.o_lane_push  = lane_push;
    assign bus.o_lane_pop   = lane_pop;
    assign bus.o_pop_err    = pop_err;
    assign bus.o_lane_data  = lane_data;
    assign bus.o_occ        = occ_flat;

endmodule

// File: tb/tb_turbo_lane_dispatcher.sv
// tb_turbo_lane_dispatcher: table-driven check of turbo_lane_dispatcher with
// NLANES=4, DEPTH=4, plus hand-written reset and policy sequences.
module tb_turbo_lane_dispatcher;

    localparam int DW     = 48;
    localparam int NLANES = 4;
    localparam int DEPTH  = 4;

    typedef struct {
        logic          push;
        logic [DW-1:0] data;
        logic          pop;
        logic [1:0]    plane;
        logic          mode;
        logic          ready;
        logic [3:0]    epush;
        logic [3:0]    epop;
        logic          err;
        logic [11:0]   eocc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;
    int   vid    = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    turbo_lane_dispatcher_if #(.DW(DW), .NLANES(NLANES), .DEPTH(DEPTH)) bus ();

    turbo_lane_dispatcher #(.DW(DW), .NLANES(NLANES), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_arst (rst),
        .bus    (bus)
    );

    function automatic logic [11:0] occv(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Occupancy after n round-robin pushes starting from an empty dispatcher.
    function automatic logic [11:0] rr_occ(input int n);
        int o[4];
        for (int k = 0; k < 4; k++) o[k] = n / 4 + ((k < n % 4) ? 1 : 0);
        return occv(o[0], o[1], o[2], o[3]);
    endfunction

    function automatic vec_t mk(input logic push, input logic [DW-1:0] data,
                                input logic pop, input logic [1:0] plane, input logic mode,
                                input logic ready, input logic [3:0] epush,
                                input logic [3:0] epop, input logic err, input logic [11:0] eocc);
        vec_t v;
        v.push = push; v.data = data; v.pop = pop; v.plane = plane; v.mode = mode;
        v.ready = ready; v.epush = epush; v.epop = epop; v.err = err; v.eocc = eocc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (step %0d): got %0h, expected %0h", nm, vid, act, exp);
    endtask

    task automatic idle_inputs();
        bus.i_push = 1'b0; bus.i_push_data = '0; bus.i_pop = 1'b0;
        bus.i_pop_lane = '0; bus.i_mode = 1'b0;
    endtask

    // Called at posedge+1: drive, check ready, queue expectation, then compare
    // the registered outputs one edge later.
    task automatic apply(input vec_t v);
        vec_t e;
        vid++;
        bus.i_push = v.push; bus.i_push_data = v.data; bus.i_pop = v.pop;
        bus.i_pop_lane = v.plane; bus.i_mode = v.mode;
        #1;
        chk("push_ready", 64'(bus.o_push_ready), 64'(v.ready));
        sb.push_back(v);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("lane_push", 64'(bus.o_lane_push), 64'(e.epush));
        chk("lane_pop", 64'(bus.o_lane_pop), 64'(e.epop));
        chk("pop_err", 64'(bus.o_pop_err), 64'(e.err));
        chk("occ", 64'(bus.o_occ), 64'(e.eocc));
        for (int k = 0; k < NLANES; k++) begin
            if (e.epush[k]) chk("lane_data", 64'(bus.o_lane_data[k*DW +: DW]), 64'(e.data));
        end
        idle_inputs();
    endtask

    task automatic check_cleared();
        chk("rst_lane_push", 64'(bus.o_lane_push), 64'd0);
        chk("rst_lane_pop", 64'(bus.o_lane_pop), 64'd0);
        chk("rst_pop_err", 64'(bus.o_pop_err), 64'd0);
        chk("rst_lane_data", 64'(|bus.o_lane_data), 64'd0);
        chk("rst_occ", 64'(bus.o_occ), 64'd0);
        chk("rst_ready", 64'(bus.o_push_ready), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        #1;
        vid++;
        check_cleared();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // Round-robin fill to full, then full/empty/same-cycle corners.
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 48'hA5A5_0000_0000 + 48'(i), 0, 0, 0, 1, 4'(1 << (i % 4)), 0, 0, rr_occ(i + 1)));
        tbl.push_back(mk(1, 48'h0BAD_0000_0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, occv(4, 4, 4, 4)));
        tbl.push_back(mk(1, 48'h0BAD_0000_0001, 1, 2, 0, 0, 4'b0000, 4'b0100, 0, occv(4, 4, 3, 4)));
        tbl.push_back(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0100, 0, occv(4, 4, 2, 4)));
        tbl.push_back(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0100, 0, occv(4, 4, 1, 4)));
        tbl.push_back(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(4, 4, 1, 3)));
        tbl.push_back(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(4, 4, 1, 2)));
        tbl.push_back(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(4, 4, 1, 1)));
        tbl.push_back(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(4, 4, 1, 0)));
        tbl.push_back(mk(1, 48'hC1C1_C1C1_0001, 0, 0, 0, 1, 4'b0100, 4'b0000, 0, occv(4, 4, 2, 0)));
        tbl.push_back(mk(1, 48'hC2C2_C2C2_0002, 0, 0, 0, 1, 4'b1000, 4'b0000, 0, occv(4, 4, 2, 1)));
        tbl.push_back(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(4, 4, 2, 0)));
        tbl.push_back(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0100, 0, occv(4, 4, 1, 0)));
        tbl.push_back(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0100, 0, occv(4, 4, 0, 0)));
        tbl.push_back(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0000, 1, occv(4, 4, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, occv(4, 4, 0, 0)));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 4'b0000, 4'b0010, 0, occv(4, 3, 0, 0)));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 4'b0000, 4'b0010, 0, occv(4, 2, 0, 0)));
        tbl.push_back(mk(1, 48'hC3C3_C3C3_0003, 1, 1, 0, 1, 4'b0010, 4'b0010, 0, occv(4, 2, 0, 0)));
        tbl.push_back(mk(1, 48'hC4C4_C4C4_0004, 1, 2, 0, 1, 4'b0100, 4'b0000, 1, occv(4, 2, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, occv(4, 2, 1, 0)));
        tbl.push_back(mk(1, 48'hC5C5_C5C5_0005, 1, 0, 0, 1, 4'b1000, 4'b0001, 0, occv(3, 2, 1, 1)));

        do_reset();
        foreach (tbl[i]) apply(tbl[i]);

        // Policy select: reach occ={3,1,1,2} with rr_ptr=2.
        do_reset();
        for (int i = 0; i < 10; i++)
            apply(mk(1, 48'hE000_0000_0000 + 48'(i), 0, 0, 0, 1, 4'(1 << (i % 4)), 0, 0, rr_occ(i + 1)));
        apply(mk(0, 0, 1, 1, 0, 1, 4'b0000, 4'b0010, 0, occv(3, 2, 2, 2)));
        apply(mk(0, 0, 1, 1, 0, 1, 4'b0000, 4'b0010, 0, occv(3, 1, 2, 2)));
        apply(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0100, 0, occv(3, 1, 1, 2)));
`ifdef TURBO_DISP_LEAST_OCC_EN
        apply(mk(1, 48'hE1E1_0000_0001, 0, 0, 1, 1, 4'b0010, 4'b0000, 0, occv(3, 2, 1, 2)));
        apply(mk(1, 48'hE1E1_0000_0002, 0, 0, 1, 1, 4'b0100, 4'b0000, 0, occv(3, 2, 2, 2)));
        apply(mk(1, 48'hE1E1_0000_0003, 0, 0, 0, 1, 4'b0100, 4'b0000, 0, occv(3, 2, 3, 2)));
`else
        apply(mk(1, 48'hE1E1_0000_0001, 0, 0, 1, 1, 4'b0100, 4'b0000, 0, occv(3, 1, 2, 2)));
        apply(mk(1, 48'hE1E1_0000_0002, 0, 0, 1, 1, 4'b1000, 4'b0000, 0, occv(3, 1, 2, 3)));
        apply(mk(1, 48'hE1E1_0000_0003, 0, 0, 0, 1, 4'b0001, 4'b0000, 0, occv(4, 1, 2, 3)));
`endif

        // Asynchronous reset in the middle of a burst with occ={3,2,1,0}.
        do_reset();
        for (int i = 0; i < 9; i++)
            apply(mk(1, 48'hF000_0000_0000 + 48'(i), 0, 0, 0, 1, 4'(1 << (i % 4)), 0, 0, rr_occ(i + 1)));
        apply(mk(0, 0, 1, 2, 0, 1, 4'b0000, 4'b0100, 0, occv(3, 2, 1, 2)));
        apply(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(3, 2, 1, 1)));
        apply(mk(0, 0, 1, 3, 0, 1, 4'b0000, 4'b1000, 0, occv(3, 2, 1, 0)));
        vid++;
        bus.i_push = 1'b1; bus.i_push_data = 48'hF1F1_F1F1_F1F1;
        @(posedge clk); #1;
        chk("burst_push", 64'(bus.o_lane_push), 64'b0010);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check_cleared();
        @(posedge clk); #1;
        rst = 1'b0;
        apply(mk(1, 48'hF2F2_F2F2_F2F2, 0, 0, 0, 1, 4'b0001, 4'b0000, 0, occv(1, 0, 0, 0)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
